cpc_lowrom_bank_ctrl: RTL
=========================

Name: cpc_lowrom_bank_ctrl

Overview:
- Bus-snooping controller for a multi-bank low ROM expansion board on the Amstrad CPC expansion connector.
- Decodes Z80 I/O writes to one control port and runs an unlock key sequence before the bank/enable register may change.
- Drives the ROM chip select, the ROMDIS override and the upper flash address lines (bank select) from that register.
- Sits between the CPC bus and a 128K-class flash/EPROM, replacing discrete gating logic.

Parameters:
- PORT_ADDR, 16'hFEE8: full 16-bit I/O address of the control port (A15..A0).
- BANK_BITS, 3: bank select width, legal range 1..5.
- KEY1, 8'hA5: first unlock byte.
- KEY2, 8'h5A: second unlock byte.
- RESET_EN, 1: value of the enable bit after reset.
- RESET_BANK, 0: value of the bank register after reset.

Ports:
- CLK  in  1  CPC 4 MHz Z80 clock; all state updates on the rising edge.
- RESET_B  in  1  asynchronous active-low reset.
- A  in  16  Z80 address bus.
- D  in  8  Z80 data bus, input sampling.
- IOREQ_B  in  1  Z80 I/O request, active low.
- WR_B  in  1  Z80 write strobe, active low.
- RD_B  in  1  Z80 read strobe, active low.
- ROMEN_B  in  1  gate-array ROM enable, active low.
- DISABLE  in  1  board link/switch, active high, static.
- ROMCS_B  out  1  ROM chip select, active low.
- ROMDIS  out  1  internal ROM disable, active high (board drives it through a diode).
- BANK  out  BANK_BITS  ROM upper address lines.
- DOUT  out  8  readback data.
- DOE  out  1  readback output enable, active high.

Behaviour:
- Reset (async, RESET_B low):
  - FSM = LOCKED, en = RESET_EN, bank = RESET_BANK.
  - Write-seen flag iowr_q = 1. A write still in progress at reset release is therefore ignored.
- Write detect, each CLK rise:
  - iowr = !IOREQ_B & !WR_B & (A == PORT_ADDR).
  - Event = iowr & !iowr_q, then iowr_q <= iowr.
  - D is captured on the event edge. Exactly one event per Z80 OUT, regardless of wait states.
- FSM, advancing only on events; non-matching addresses are never events:
  - LOCKED: data == KEY1 -> KEY1_OK; else stay.
  - KEY1_OK: data == KEY2 -> UNLOCKED; data == KEY1 -> KEY1_OK (re-arm); else -> LOCKED.
  - UNLOCKED: en <= data[7], bank <= data[BANK_BITS-1:0], -> LOCKED (one-shot). Data bits 6..BANK_BITS are ignored.
- Register timing: BANK and en change on the event edge. New values are visible one CLK after detection. An OUT cannot overlap a ROM fetch, so there is no mid-access switch.
- Combinational outputs:
  - act = en & !DISABLE.
  - ROMCS_B = ROMEN_B | A[14] | !act.
  - ROMDIS = act & !A[14].
- DISABLE:
  - Forces ROMCS_B = 1 and ROMDIS = 0 immediately.
  - Does not block the FSM or register updates.
- BANK: driven directly from the register, reset value RESET_BANK.
- Reset mid-sequence (e.g. in KEY1_OK): returns to LOCKED; the unlock must restart.

Optional Feature:
- Macro: LOWROM_READBACK_EN.
- Defined:
  - DOE = !IOREQ_B & !RD_B & (A == PORT_ADDR), combinational.
  - DOUT = {en, state[1:0], bank zero-extended to 5 bits}.
  - State codes: LOCKED = 00, KEY1_OK = 01, UNLOCKED = 10.
  - Reads never advance the FSM.
- Undefined: DOUT = 8'h00 and DOE = 0 constantly; no read decode logic is present.

Test Plan:
- Reset, DISABLE=0, ROMEN_B=0, A=16'h0123 -> ROMCS_B=0, ROMDIS=1, BANK=0. Then A=16'h4000 -> ROMCS_B=1, ROMDIS=0.
- OUT &FEE8 with A5, 5A, 83 -> BANK=3, en=1, FSM back to LOCKED. A further OUT 85 -> BANK stays 3.
- OUT &FEE8 with A5, A5, 5A, 02 -> BANK=2 (re-arm path). OUT A5, 11, 5A, 00 -> no change, FSM LOCKED.
- Unlock, then OUT 00 -> en=0: ROMCS_B=1 and ROMDIS=0 for all A with ROMEN_B=0. Then DISABLE=1 with en=1 -> same outputs. A key sequence under DISABLE=1 still updates BANK.
- OUT A5 to &FEE9 then 5A, 81 to &FEE8 -> no change. An OUT held 3 wait states counts as a single event. Reset asserted in KEY1_OK, then 5A, 81 -> no change.
- With LOWROM_READBACK_EN, after unlock and OUT 85 -> IN &FEE8 gives DOE=1, DOUT=8'h85. After OUT A5 -> DOUT=8'hA5 (state 01). Without the macro -> DOE stays 0.

Source files
------------

// File: rtl/cpc_lowrom_bank_ctrl_if.sv
// ============================================================================
// cpc_lowrom_bank_ctrl_if
// ----------------------------------------------------------------------------
// Purpose : Groups the CPC expansion-connector signals seen by the low ROM
//           bank controller. It covers the Z80 address, data and strobes, the
//           gate-array ROM enable and the board DISABLE link, plus the ROM
//           chip select, ROMDIS, bank lines and readback bus that the
//           controller drives back.
//
// Signals :
//   A        Z80 address bus A15..A0
//   D        Z80 data bus (sampled by the controller)
//   IOREQ_B  Z80 I/O request, active low
//   WR_B     Z80 write strobe, active low
//   RD_B     Z80 read strobe, active low
//   ROMEN_B  gate-array ROM enable, active low
//   DISABLE  board link/switch, active high, static
//   ROMCS_B  ROM chip select, active low
//   ROMDIS   internal ROM disable, active high
//   BANK     ROM upper address lines (BANK_BITS wide)
//   DOUT     readback data
//   DOE      readback output enable, active high
//
// Modports:
//   master - the CPC bus side (drives the Z80 signals, observes the outputs)
//   slave  - the bank controller
//
// BANK_BITS must match the BANK_BITS of the controller it is connected to.
// ============================================================================
interface cpc_lowrom_bank_ctrl_if #(
    parameter int BANK_BITS = 3
);
    logic [15:0]          A;
    logic [7:0]           D;
    logic                 IOREQ_B;
    logic                 WR_B;
    logic                 RD_B;
    logic                 ROMEN_B;
    logic                 DISABLE;
    logic                 ROMCS_B;
    logic                 ROMDIS;
    logic [BANK_BITS-1:0] BANK;
    logic [7:0]           DOUT;
    logic                 DOE;

    modport master (
        output A, D, IOREQ_B, WR_B, RD_B, ROMEN_B, DISABLE,
        input  ROMCS_B, ROMDIS, BANK, DOUT, DOE
    );

    modport slave (
        input  A, D, IOREQ_B, WR_B, RD_B, ROMEN_B, DISABLE,
        output ROMCS_B, ROMDIS, BANK, DOUT, DOE
    );
endinterface

// File: rtl/cpc_lowrom_bank_ctrl.sv
// ============================================================================
// cpc_lowrom_bank_ctrl
// ----------------------------------------------------------------------------
// Purpose : Bus-snooping controller for a multi-bank low ROM expansion board
//           on the Amstrad CPC. It watches Z80 OUT cycles to one control
//           port. A two-byte unlock key (KEY1, KEY2) arms the controller, and
//           the next write to the port loads the enable bit (data[7]) and the
//           bank number (data[BANK_BITS-1:0]). The controller then locks
//           again. The registers drive the flash upper address lines, the ROM
//           chip select and the ROMDIS override.
//
// Ports   :
//   CLK      CPC 4 MHz Z80 clock, all state changes on the rising edge
//   RESET_B  asynchronous active-low reset
//   bus      cpc_lowrom_bank_ctrl_if.slave: Z80 bus inputs, ROMEN_B, DISABLE,
//            and the ROMCS_B / ROMDIS / BANK / DOUT / DOE outputs
//
// Build option:
//   LOWROM_READBACK_EN - when defined, an IN from the control port returns
//   {en, state[1:0], bank zero-extended to 5 bits} with DOE asserted. When
//   undefined, DOUT is 8'h00 and DOE is 0, and no read decode exists.
// ============================================================================
module cpc_lowrom_bank_ctrl #(
    parameter logic [15:0]          PORT_ADDR  = 16'hFEE8,
    parameter int                   BANK_BITS  = 3,
    parameter logic [7:0]           KEY1       = 8'hA5,
    parameter logic [7:0]           KEY2       = 8'h5A,
    parameter bit                   RESET_EN   = 1'b1,
    parameter logic [BANK_BITS-1:0] RESET_BANK = '0
) (
    input  logic                  CLK,
    input  logic                  RESET_B,
    cpc_lowrom_bank_ctrl_if.slave bus
);

    // The state codes are visible through readback, so they are fixed here.
    typedef enum logic [1:0] {
        LOCKED   = 2'b00,
        KEY1_OK  = 2'b01,
        UNLOCKED = 2'b10
    } state_t;

    state_t               r_state;
    logic                 r_en;
    logic [BANK_BITS-1:0] r_bank;
    logic                 r_iowrQ;

    logic w_iowr;
    logic w_event;
    logic w_act;

    // An OUT to the control port is recognised as soon as IOREQ_B and WR_B
    // are both low with the port address on the bus.
    assign w_iowr = !bus.IOREQ_B && !bus.WR_B && (bus.A == PORT_ADDR);

    // The event is the first clock that sees the write.
    // Wait states keep w_iowr high, but r_iowrQ suppresses the repeats, so
    // each OUT produces exactly one event.
    assign w_event = w_iowr && !r_iowrQ;

    // Unlock sequencer and the bank/enable register share one block, because
    // the register may only load in the UNLOCKED state.
    // r_iowrQ resets to 1. A write that is still active when reset is
    // released therefore cannot produce a spurious event.
    // The FSM acts on D in the same clock as the event.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            r_state <= LOCKED;
            r_en    <= RESET_EN;
            r_bank  <= RESET_BANK;
            r_iowrQ <= 1'b1;
        end else begin
            r_iowrQ <= w_iowr;
            if (w_event) begin
                case (r_state)
                    LOCKED: begin
                        if (bus.D == KEY1)
                            r_state <= KEY1_OK;
                    end
                    KEY1_OK: begin
                        // A repeated KEY1 re-arms instead of aborting. An
                        // unlock retried after a stray byte then still works.
                        if (bus.D == KEY2)
                            r_state <= UNLOCKED;
                        else if (bus.D == KEY1)
                            r_state <= KEY1_OK;
                        else
                            r_state <= LOCKED;
                    end
                    UNLOCKED: begin
                        r_en    <= bus.D[7];
                        r_bank  <= bus.D[BANK_BITS-1:0];
                        r_state <= LOCKED;
                    end
                    default: begin
                        r_state <= LOCKED;
                    end
                endcase
            end
        end
    end

    // DISABLE masks the outputs only. The register can still be programmed
    // while the board is switched off.
    assign w_act = r_en && !bus.DISABLE;

    // The board serves the lower 16K only, so A14 low selects the ROM.
    assign bus.ROMCS_B = bus.ROMEN_B || bus.A[14] || !w_act;
    assign bus.ROMDIS  = w_act && !bus.A[14];
    assign bus.BANK    = r_bank;

`ifdef LOWROM_READBACK_EN
    logic [4:0] w_bank5;
    logic [1:0] w_stateCode;

    // The bank is always presented as 5 bits so that the DOUT layout does not
    // depend on BANK_BITS.
    always_comb begin
        w_bank5                  = '0;
        w_bank5[BANK_BITS-1:0]   = r_bank;
    end

    assign w_stateCode = r_state;
    assign bus.DOE     = !bus.IOREQ_B && !bus.RD_B && (bus.A == PORT_ADDR);
    assign bus.DOUT    = {r_en, w_stateCode, w_bank5};
`else
    logic w_unusedRdB;

    // Without readback the read strobe is not needed.
    assign w_unusedRdB = bus.RD_B;
    assign bus.DOE     = 1'b0;
    assign bus.DOUT    = 8'h00;
`endif

endmodule
